// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a synchronous-read instruction memory and detects halt.
// Optional FETCH_PERF_COUNT_EN adds saturating cycle/retired-fetch counters.
module instr_fetch #(
  parameter int                   PC_W        = 10,
  parameter int                   INSTR_W     = 9,
  parameter logic [PC_W-1:0]      START_PC    = '0,
  parameter logic [INSTR_W-1:0]   HALT_OPCODE = 9'h1FF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               done
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0]        cycle_count,
  output logic [15:0]        instr_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic              valid_q;
  logic              done_q;
  logic              halt_det_s;

  assign halt_det_s  = (state_q == S_RUN) && valid_q && (imem_rdata == HALT_OPCODE) && !stall;
  assign imem_addr   = pc_d;
  assign instruction = imem_rdata;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign done        = done_q;

  // Next fetch address; presenting it to the memory now makes imem_rdata == mem[pc] next cycle.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) pc_d = START_PC;
        else       pc_d = pc_q;
      end
      S_RUN: begin
        if (stall)                            pc_d = pc_q;
        else if (halt_det_s)                  pc_d = pc_q;
        else if (branch_taken && valid_q)     pc_d = branch_target;
        else                                  pc_d = pc_q + PC_W'(1);
      end
      default: pc_d = pc_q;
    endcase
  end

  // Control FSM with registered valid/done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (halt_det_s) begin
            state_q <= S_HALT;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] cycle_q;
  logic [15:0] instr_q;

  // Saturating counters; cleared by an accepted start, frozen outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 16'd0;
      instr_q <= 16'd0;
    end else if (start && (state_q != S_RUN)) begin
      cycle_q <= 16'd0;
      instr_q <= 16'd0;
    end else if (state_q == S_RUN) begin
      if (cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
      if (valid_q && !stall && (instr_q != 16'hFFFF)) instr_q <= instr_q + 16'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a program-level fetch model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [9:0]  branch_target = 10'd0;
  logic [9:0]  imem_addr;
  logic [8:0]  imem_rdata = 9'd0;
  logic [8:0]  instruction;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        done;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] cycle_count;
  logic [15:0] instr_count;
`endif

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .done(done)
`ifdef FETCH_PERF_COUNT_EN
    , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] mem [1024];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-level model: running flag, current PC, done flag, counters.
  logic       m_run = 1'b0;
  logic       m_done = 1'b0;
  logic [9:0] m_pc = 10'd0;
  int         m_cyc = 0;
  int         m_ins = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_pc <= 10'd0; m_cyc <= 0; m_ins <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1; m_done <= 1'b0; m_pc <= 10'd0; m_cyc <= 0; m_ins <= 0;
      end
    end else begin
      m_cyc <= (m_cyc < 65535) ? m_cyc + 1 : 65535;
      if (!stall) begin
        m_ins <= (m_ins < 65535) ? m_ins + 1 : 65535;
        if (mem[m_pc] == 9'h1FF) begin
          m_run <= 1'b0; m_done <= 1'b1;
        end else if (branch_taken) m_pc <= branch_target;
        else m_pc <= 10'((int'(m_pc) + 1) % 1024);
      end
    end
  end

  function automatic logic [9:0] exp_addr();
    if (!m_run) return start ? 10'd0 : m_pc;
    if (stall || mem[m_pc] == 9'h1FF) return m_pc;
    if (branch_taken) return branch_target;
    return 10'((int'(m_pc) + 1) % 1024);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("instr_pc", instr_pc, m_pc);
      check("instr_valid", instr_valid, m_run);
      check("done", done, m_done);
      check("imem_addr", imem_addr, exp_addr());
      if (m_run) check("instruction", instruction, mem[m_pc]);
`ifdef FETCH_PERF_COUNT_EN
      check("cycle_count", cycle_count, m_cyc);
      check("instr_count", instr_count, m_ins);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_pc", instr_pc, 10'd0);
    check("start_valid", instr_valid, 1'b1);
    check("start_done", done, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_wait", done, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    mem[0] = 9'h003; mem[1] = 9'h004; mem[2] = 9'h005; mem[3] = 9'h1FF;
    mem[10'h050] = 9'h0AA; mem[10'h051] = 9'h1FF; mem[10'h3FF] = 9'h012;

    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", instr_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pc", instr_pc, 10'd0);
    check("rst_addr", imem_addr, 10'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check("idle_valid", instr_valid, 1'b0);

    // Straight-line program to halt.
    pulse_start();
    check("instr0", instruction, 9'h003);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("seq_pc", instr_pc, 10'(i));
    end
    check("halt_instr", instruction, 9'h1FF);
    tick();
    check("halt_done", done, 1'b1);
    check("halt_valid", instr_valid, 1'b0);
    check("halt_pc", instr_pc, 10'd3);

    // Stall holds pc=2 for three cycles.
    pulse_start();
    tick(); tick();
    stall = 1'b1;
    check("stall_pc0", instr_pc, 10'd2);
    tick();
    check("stall_pc1", instr_pc, 10'd2);
    check("stall_instr", instruction, 9'h005);
    tick();
    check("stall_pc2", instr_pc, 10'd2);
    check("stall_valid", instr_valid, 1'b1);
    stall = 1'b0;
    tick();
    check("stall_release", instr_pc, 10'd3);
    wait_done(10);

    // Branch at pc=1.
    pulse_start();
    tick();
    branch_taken = 1'b1; branch_target = 10'h050;
    tick();
    branch_taken = 1'b0;
    check("br_pc", instr_pc, 10'h050);
    check("br_instr", instruction, 9'h0AA);
    wait_done(10);
    check("br_halt_pc", instr_pc, 10'h051);

    // Branch held under stall.
    pulse_start();
    tick();
    branch_taken = 1'b1; branch_target = 10'h050; stall = 1'b1;
    tick();
    check("brst_pc", instr_pc, 10'd1);
    stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("brst_target", instr_pc, 10'h050);
    wait_done(10);

    // Wrap from 0x3FF to 0.
    pulse_start();
    branch_taken = 1'b1; branch_target = 10'h3FF;
    tick();
    branch_taken = 1'b0;
    check("wrap_pc", instr_pc, 10'h3FF);
    tick();
    check("wrap_zero", instr_pc, 10'd0);
    wait_done(20);

    // Asynchronous reset mid-run at pc=5, then replay.
    mem[3] = 9'h006; mem[4] = 9'h007; mem[5] = 9'h008; mem[6] = 9'h1FF;
    pulse_start();
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_pc", instr_pc, 10'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_pc", instr_pc, 10'd0);
`ifdef FETCH_PERF_COUNT_EN
    check("mid_rst_cyc", cycle_count, 16'd0);
    check("mid_rst_ins", instr_count, 16'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_idle", instr_valid, 1'b0);
    pulse_start();
    for (int i = 1; i < 7; i++) begin
      tick();
      check("replay_pc", instr_pc, 10'(i));
    end
    tick();
    check("replay_done", done, 1'b1);

    // Randomized run against the model.
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(11) == 0) ? 9'h1FF : 9'($urandom);
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(15) == 0);
      if (!(stall && branch_taken)) begin
        branch_taken  = ($urandom_range(5) == 0);
        branch_target = 10'($urandom);
      end
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(799) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
